// File: rtl/llr_phase_former_if.sv
// Sample/LLR bus between the demodulator, the phase former and the deperforator.
// Latency: none, this is wiring only.
// Backpressure: none; the source presents data with i_vld and the sink must take it.
interface llr_phase_former_if #(
    parameter int LLR_WIDTH = 8
);
    logic                        i_vld;
    logic signed [LLR_WIDTH-1:0] i_I;
    logic signed [LLR_WIDTH-1:0] i_Q;
    logic                        i_next_phase;
    logic                        i_llr_reset;
    logic                        o_vld;
    logic signed [LLR_WIDTH-1:0] o_llr0;
    logic signed [LLR_WIDTH-1:0] o_llr1;
    logic                        o_last_phase_stb;
    logic [2:0]                  o_phase;

    // Upstream side: drives samples and phase commands, receives LLRs.
    modport master (
        output i_vld, i_I, i_Q, i_next_phase, i_llr_reset,
        input  o_vld, o_llr0, o_llr1, o_last_phase_stb, o_phase
    );

    // Phase former side.
    modport slave (
        input  i_vld, i_I, i_Q, i_next_phase, i_llr_reset,
        output o_vld, o_llr0, o_llr1, o_last_phase_stb, o_phase
    );
endinterface

// File: rtl/llr_phase_former.sv
// QPSK I/Q to rate-1/2 LLR pair former under a selectable phase hypothesis (rotation + conjugation).
// Latency: 2 cycles from i_vld to o_vld; phase commands take effect on the next sample.
// Backpressure: none; every valid sample produces a pair, optionally blanked after a phase change.
module llr_phase_former #(
    parameter int LLR_WIDTH  = 8,
    parameter int NUM_PHASES = 4,
    parameter int BLANK_LEN  = 0
) (
    input  logic              clk,
    input  logic              reset_n,
    llr_phase_former_if.slave bus
);

    localparam logic [2:0] LAST_PHASE = 3'(NUM_PHASES - 1);
    localparam logic [7:0] BLANK_LOAD = 8'(BLANK_LEN);
    localparam logic signed [LLR_WIDTH-1:0] S_MIN = {1'b1, {(LLR_WIDTH-1){1'b0}}};
    localparam logic signed [LLR_WIDTH-1:0] S_MAX = {1'b0, {(LLR_WIDTH-1){1'b1}}};

    // Negation that maps the most negative code onto the most positive one
    // instead of wrapping back to itself.
    function automatic logic signed [LLR_WIDTH-1:0] sat_neg(input logic signed [LLR_WIDTH-1:0] x);
        return (x == S_MIN) ? S_MAX : -x;
    endfunction

    // Phase hypothesis state
    logic [2:0] r_phase;
    logic       r_last_stb;
    logic [2:0] w_phase_inc;
    logic       w_cmd;

    // Stage 1: captured sample and the hypothesis it is to be decoded under
    logic                        r_s1_vld;
    logic signed [LLR_WIDTH-1:0] r_s1_i;
    logic signed [LLR_WIDTH-1:0] r_s1_q;
    logic [2:0]                  r_s1_phase;

    // Stage 2: formed LLRs
    logic                        r_o_vld;
    logic signed [LLR_WIDTH-1:0] r_llr0;
    logic signed [LLR_WIDTH-1:0] r_llr1;

    // Remaining pairs to suppress after the most recent phase command
    logic [7:0] r_blank_cnt;

    // Transform intermediates
    logic signed [LLR_WIDTH-1:0] w_i_neg;
    logic signed [LLR_WIDTH-1:0] w_q_conj;
    logic signed [LLR_WIDTH-1:0] w_q_conj_neg;
    logic signed [LLR_WIDTH-1:0] w_llr0;
    logic signed [LLR_WIDTH-1:0] w_llr1;

    assign w_cmd       = bus.i_next_phase | bus.i_llr_reset;
    assign w_phase_inc = (r_phase == LAST_PHASE) ? 3'd0 : r_phase + 3'd1;

    // Phase register and last-hypothesis strobe; llr reset overrides next-phase and never strobes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_phase    <= 3'd0;
            r_last_stb <= 1'b0;
        end else begin
            r_last_stb <= 1'b0;
            if (bus.i_llr_reset) begin
                r_phase <= 3'd0;
            end else if (bus.i_next_phase) begin
                r_phase    <= w_phase_inc;
                r_last_stb <= (w_phase_inc == LAST_PHASE);
            end
        end
    end

    // Stage 1: register the sample with the phase in force this cycle, so a
    // command arriving alongside a sample does not affect that sample.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_s1_vld   <= 1'b0;
            r_s1_i     <= '0;
            r_s1_q     <= '0;
            r_s1_phase <= 3'd0;
        end else begin
            r_s1_vld <= bus.i_vld;
            if (bus.i_vld) begin
                r_s1_i     <= bus.i_I;
                r_s1_q     <= bus.i_Q;
                r_s1_phase <= r_phase;
            end
        end
    end

    // Conjugate first (bit 2), then rotate by a multiple of 90 degrees (bits 1:0).
    assign w_i_neg      = sat_neg(r_s1_i);
    assign w_q_conj     = r_s1_phase[2] ? sat_neg(r_s1_q) : r_s1_q;
    assign w_q_conj_neg = sat_neg(w_q_conj);

    // Rotation select
    always_comb begin
        w_llr0 = r_s1_i;
        w_llr1 = w_q_conj;
        case (r_s1_phase[1:0])
            2'd0: begin
                w_llr0 = r_s1_i;
                w_llr1 = w_q_conj;
            end
            2'd1: begin
                w_llr0 = w_q_conj_neg;
                w_llr1 = r_s1_i;
            end
            2'd2: begin
                w_llr0 = w_i_neg;
                w_llr1 = w_q_conj_neg;
            end
            default: begin
                w_llr0 = w_q_conj;
                w_llr1 = w_i_neg;
            end
        endcase
    end

    // Blank counter: any command reloads it; each pair reaching stage 2 while
    // it is nonzero consumes one count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_blank_cnt <= 8'd0;
        end else if (w_cmd) begin
            r_blank_cnt <= BLANK_LOAD;
        end else if (r_s1_vld && (r_blank_cnt != 8'd0)) begin
            r_blank_cnt <= r_blank_cnt - 8'd1;
        end
    end

    // Stage 2: register LLRs for every valid pair (blanked ones too); only
    // the valid flag is suppressed while blanking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_o_vld <= 1'b0;
            r_llr0  <= '0;
            r_llr1  <= '0;
        end else begin
            r_o_vld <= r_s1_vld && (r_blank_cnt == 8'd0);
            if (r_s1_vld) begin
                r_llr0 <= w_llr0;
                r_llr1 <= w_llr1;
            end
        end
    end

    assign bus.o_vld            = r_o_vld;
    assign bus.o_llr0           = r_llr0;
    assign bus.o_llr1           = r_llr1;
    assign bus.o_last_phase_stb = r_last_stb;
    assign bus.o_phase          = r_phase;

endmodule

// File: tb/tb_llr_phase_former.sv
// Bench for llr_phase_former: four instances with different hypothesis counts and blanking share one stimulus.
// Latency: reference model predicts each pair one edge after capture, i.e. visible two cycles after i_vld.
// Backpressure: none; inputs are driven on the falling edge, outputs compared on the falling edge.
module tb_llr_phase_former;

    localparam int W = 8;
    localparam int NPH [4] = '{4, 8, 5, 1};
    localparam int BLN [4] = '{0, 0, 3, 0};

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    llr_phase_former_if #(.LLR_WIDTH(W)) if0 ();
    llr_phase_former_if #(.LLR_WIDTH(W)) if1 ();
    llr_phase_former_if #(.LLR_WIDTH(W)) if2 ();
    llr_phase_former_if #(.LLR_WIDTH(W)) if3 ();

    llr_phase_former #(.LLR_WIDTH(W), .NUM_PHASES(NPH[0]), .BLANK_LEN(BLN[0]))
        dut0 (.clk(clk), .reset_n(reset_n), .bus(if0));
    llr_phase_former #(.LLR_WIDTH(W), .NUM_PHASES(NPH[1]), .BLANK_LEN(BLN[1]))
        dut1 (.clk(clk), .reset_n(reset_n), .bus(if1));
    llr_phase_former #(.LLR_WIDTH(W), .NUM_PHASES(NPH[2]), .BLANK_LEN(BLN[2]))
        dut2 (.clk(clk), .reset_n(reset_n), .bus(if2));
    llr_phase_former #(.LLR_WIDTH(W), .NUM_PHASES(NPH[3]), .BLANK_LEN(BLN[3]))
        dut3 (.clk(clk), .reset_n(reset_n), .bus(if3));

    logic              ob_vld [4];
    logic signed [W-1:0] ob_l0 [4];
    logic signed [W-1:0] ob_l1 [4];
    logic              ob_stb [4];
    logic [2:0]        ob_ph  [4];

    assign ob_vld[0] = if0.o_vld;  assign ob_l0[0] = if0.o_llr0;  assign ob_l1[0] = if0.o_llr1;
    assign ob_stb[0] = if0.o_last_phase_stb;  assign ob_ph[0] = if0.o_phase;
    assign ob_vld[1] = if1.o_vld;  assign ob_l0[1] = if1.o_llr0;  assign ob_l1[1] = if1.o_llr1;
    assign ob_stb[1] = if1.o_last_phase_stb;  assign ob_ph[1] = if1.o_phase;
    assign ob_vld[2] = if2.o_vld;  assign ob_l0[2] = if2.o_llr0;  assign ob_l1[2] = if2.o_llr1;
    assign ob_stb[2] = if2.o_last_phase_stb;  assign ob_ph[2] = if2.o_phase;
    assign ob_vld[3] = if3.o_vld;  assign ob_l0[3] = if3.o_llr0;  assign ob_l1[3] = if3.o_llr1;
    assign ob_stb[3] = if3.o_last_phase_stb;  assign ob_ph[3] = if3.o_phase;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state, per instance.
    int m_ph [4];     // current hypothesis
    int m_stb [4];    // expected strobe after the last edge
    int m_cmd [4];    // a command has been seen since reset
    int m_since [4];  // valid samples captured since the last command
    int p_vld [4], p_blk [4], p_l0 [4], p_l1 [4];  // sample captured on the last edge
    int m_vld [4], m_l0 [4], m_l1 [4];             // expected outputs after the last edge

    task automatic chk(input string tag, input int k, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d observed=%0d expected=%0d", tag, k, obs, exp);
        end
    endtask

    function automatic int sneg(input int x);
        return (x == -(1 << (W - 1))) ? (1 << (W - 1)) - 1 : -x;
    endfunction

    // Hypothesis applied to one complex sample: optional conjugate, then j^k rotation.
    function automatic void xform(input int ph, input int i, input int q, output int a, output int b);
        int qc;
        qc = (ph >= 4) ? sneg(q) : q;
        case (ph % 4)
            0:       begin a = i;        b = qc;       end
            1:       begin a = sneg(qc); b = i;        end
            2:       begin a = sneg(i);  b = sneg(qc); end
            default: begin a = qc;       b = sneg(i);  end
        endcase
    endfunction

    function automatic void model_reset();
        for (int k = 0; k < 4; k++) begin
            m_ph[k] = 0; m_stb[k] = 0; m_cmd[k] = 0; m_since[k] = 0;
            p_vld[k] = 0; p_blk[k] = 0; p_l0[k] = 0; p_l1[k] = 0;
            m_vld[k] = 0; m_l0[k] = 0; m_l1[k] = 0;
        end
    endfunction

    // Effect of one rising edge with the given inputs.
    function automatic void model_edge(input int vld, input int i, input int q, input int np, input int lr);
        for (int k = 0; k < 4; k++) begin
            m_vld[k] = (p_vld[k] != 0 && p_blk[k] == 0) ? 1 : 0;
            if (p_vld[k] != 0) begin
                m_l0[k] = p_l0[k];
                m_l1[k] = p_l1[k];
            end
            if (np != 0 || lr != 0) begin
                m_cmd[k] = 1;
                m_since[k] = 0;
            end
            p_vld[k] = vld;
            if (vld != 0) begin
                m_since[k]++;
                p_blk[k] = (m_cmd[k] != 0 && m_since[k] <= BLN[k]) ? 1 : 0;
                xform(m_ph[k], i, q, p_l0[k], p_l1[k]);
            end
            m_stb[k] = 0;
            if (lr != 0) begin
                m_ph[k] = 0;
            end else if (np != 0) begin
                m_ph[k] = (m_ph[k] == NPH[k] - 1) ? 0 : m_ph[k] + 1;
                m_stb[k] = (m_ph[k] == NPH[k] - 1) ? 1 : 0;
            end
        end
    endfunction

    task automatic drive(input int vld, input int i, input int q, input int np, input int lr);
        if0.i_vld = vld[0]; if0.i_I = W'(i); if0.i_Q = W'(q); if0.i_next_phase = np[0]; if0.i_llr_reset = lr[0];
        if1.i_vld = vld[0]; if1.i_I = W'(i); if1.i_Q = W'(q); if1.i_next_phase = np[0]; if1.i_llr_reset = lr[0];
        if2.i_vld = vld[0]; if2.i_I = W'(i); if2.i_Q = W'(q); if2.i_next_phase = np[0]; if2.i_llr_reset = lr[0];
        if3.i_vld = vld[0]; if3.i_I = W'(i); if3.i_Q = W'(q); if3.i_next_phase = np[0]; if3.i_llr_reset = lr[0];
    endtask

    task automatic check_all();
        for (int k = 0; k < 4; k++) begin
            chk("o_vld", k, ob_vld[k], m_vld[k]);
            chk("o_phase", k, ob_ph[k], m_ph[k]);
            chk("o_last_phase_stb", k, ob_stb[k], m_stb[k]);
            if (m_vld[k] != 0) begin
                chk("o_llr0", k, ob_l0[k], m_l0[k]);
                chk("o_llr1", k, ob_l1[k], m_l1[k]);
            end
        end
    endtask

    // One clock: apply inputs at the falling edge, let the rising edge pass,
    // compare at the next falling edge.
    task automatic cyc(input int vld, input int i, input int q, input int np, input int lr);
        drive(vld, i, q, np, lr);
        model_edge(vld, i, q, np, lr);
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0);
        #1;
        for (int k = 0; k < 4; k++) begin
            chk("rst_o_vld", k, ob_vld[k], 0);
            chk("rst_o_llr0", k, ob_l0[k], 0);
            chk("rst_o_llr1", k, ob_l1[k], 0);
            chk("rst_o_stb", k, ob_stb[k], 0);
            chk("rst_o_phase", k, ob_ph[k], 0);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    function automatic int rsamp();
        int r;
        r = int'($urandom_range(0, 15));
        if (r == 0) return -(1 << (W - 1));
        if (r == 1) return (1 << (W - 1)) - 1;
        return int'($urandom_range(0, 255)) - 128;
    endfunction

    initial begin
        int e0 [3];
        int e1 [3];
        int nlow;
        e0 = '{3, -5, -3};
        e1 = '{5, 3, -5};

        do_reset();

        // Some traffic, then reset in the middle of the stream.
        for (int n = 0; n < 6; n++) cyc(1, rsamp(), rsamp(), 0, 0);
        do_reset();

        // Phase 0 pass-through.
        for (int n = 0; n < 10; n++) cyc(1, 5, -3, 0, 0);
        chk("p0_vld", 0, ob_vld[0], 1);
        chk("p0_llr0", 0, ob_l0[0], 5);
        chk("p0_llr1", 0, ob_l1[0], -3);
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        // Three steps through the hypotheses.
        for (int s = 0; s < 3; s++) begin
            cyc(0, 0, 0, 1, 0);
            chk("step_stb", 0, ob_stb[0], (s == 2) ? 1 : 0);
            cyc(1, 5, -3, 0, 0);
            cyc(0, 0, 0, 0, 0);
            chk("step_llr0", 0, ob_l0[0], e0[s]);
            chk("step_llr1", 0, ob_l1[0], e1[s]);
        end
        chk("step_phase", 0, ob_ph[0], 3);

        // Wrap, then simultaneous reset + next.
        cyc(0, 0, 0, 1, 0);
        chk("wrap_phase", 0, ob_ph[0], 0);
        chk("wrap_stb", 0, ob_stb[0], 0);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 1);
        chk("both_phase", 0, ob_ph[0], 0);
        chk("both_stb", 0, ob_stb[0], 0);
        cyc(0, 0, 0, 0, 0);

        // Conjugation and saturation on the 8-hypothesis instance.
        cyc(0, 0, 0, 0, 1);
        for (int n = 0; n < 4; n++) cyc(0, 0, 0, 1, 0);
        chk("ph4_phase", 1, ob_ph[1], 4);
        cyc(1, -128, 7, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("ph4_llr0", 1, ob_l0[1], -128);
        chk("ph4_llr1", 1, ob_l1[1], -7);
        cyc(0, 0, 0, 1, 0);
        cyc(0, 0, 0, 1, 0);
        cyc(1, -128, 7, 0, 0);
        cyc(0, 0, 0, 0, 0);
        chk("ph6_llr0_sat", 1, ob_l0[1], 127);

        // Blanking: one command under continuous traffic.
        for (int n = 0; n < 4; n++) cyc(1, rsamp(), rsamp(), 0, 0);
        nlow = 0;
        cyc(1, rsamp(), rsamp(), 1, 0);
        if (!ob_vld[2]) nlow++;
        for (int n = 0; n < 8; n++) begin
            cyc(1, rsamp(), rsamp(), 0, 0);
            if (!ob_vld[2]) nlow++;
        end
        chk("blank_single", 2, nlow, 3);

        // Blanking: second command one cycle into the first blank window.
        nlow = 0;
        cyc(1, rsamp(), rsamp(), 1, 0);
        if (!ob_vld[2]) nlow++;
        cyc(1, rsamp(), rsamp(), 1, 0);
        if (!ob_vld[2]) nlow++;
        for (int n = 0; n < 8; n++) begin
            cyc(1, rsamp(), rsamp(), 0, 0);
            if (!ob_vld[2]) nlow++;
        end
        chk("blank_extend", 2, nlow, 4);

        // Sample on the same cycle as the command keeps the old phase.
        cyc(0, 0, 0, 0, 1);
        cyc(1, 5, -3, 1, 0);
        cyc(1, 5, -3, 0, 0);
        chk("same_cyc_llr0", 0, ob_l0[0], 5);
        chk("same_cyc_llr1", 0, ob_l1[0], -3);
        cyc(0, 0, 0, 0, 0);
        chk("next_cyc_llr0", 0, ob_l0[0], 3);
        chk("next_cyc_llr1", 0, ob_l1[0], 5);

        // Randomised traffic and commands, with one reset in the middle.
        for (int n = 0; n < 600; n++) begin
            if (n == 300) do_reset();
            cyc(($urandom_range(0, 3) != 0) ? 1 : 0, rsamp(), rsamp(),
                ($urandom_range(0, 7) == 0) ? 1 : 0,
                ($urandom_range(0, 19) == 0) ? 1 : 0);
        end
        cyc(0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
